regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the multi-FU scoreboard core. It sits between the control unit, which reads operands, and the functional units, which write back results. Beyond the fixed 10-write/2-read file it replaces, it adds:
- configurable width, depth and port counts;
- deterministic priority between same-address writes;
- optional write-to-read bypass;
- per-register pending (busy) bits driven by issue and writeback;
- a saturating write-collision counter.

## Interface
Parameters:
- XLEN, 32, data width
- DEPTH, 32, number of architectural registers; index 0 hardwired to zero
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NUM_WR, 10, write ports; port k maps to FU k (ALU1..3, JUMP, MEM1..2, MUL1..2, DIV1..2)
- NUM_RD, 2, read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads, 0 = reads return stored value

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*AW  read addresses, port j at bits [j*AW +: AW]
- rd_data  out  NUM_RD*XLEN  read data
- rd_busy  out  NUM_RD  pending-write flag of each read register
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*XLEN  write data
- issue_en  in  1  mark issue_addr pending (new producer issued)
- issue_addr  in  AW  destination register being issued
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data, never bypassed
- coll_cnt  out  16  saturating count of cycles containing a write collision

## Operation
- Storage covers regs[1..DEPTH-1] and busy[1..DEPTH-1]. Address 0 reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Write: on the rising edge, every port k with wr_en[k]=1 and wr_addr[k]!=0 writes wr_data[k].
  - Same-address collision: the highest-index port wins; lower ports are dropped.
- Read, combinational, for each read port j with address a (a!=0):
  - BYPASS=1 and some enabled port writes a this cycle: rd_data = winning port's data.
  - Otherwise: rd_data = regs[a].
- Busy bits:
  - Set on an edge where issue_en=1 for issue_addr.
  - Cleared on an edge where any enabled write targets that register.
  - Same-edge issue and writeback to the same register: busy ends at 1 (the new producer dominates).
- rd_busy[j] = busy[a]. With BYPASS=1, rd_busy[j] is forced to 0 when a same-cycle write to a exists and issue_en does not target a.
- Collision: a cycle counts when at least two enabled write ports share a non-zero address. coll_cnt increments by 1 per such cycle and saturates at 16'hFFFF. Multiple colliding pairs in one cycle still count once.
- dbg_data = 0 if dbg_addr==0, else regs[dbg_addr] (stored value only).
- Addresses >= DEPTH (when DEPTH is not a power of two): reads return 0 with busy 0; writes and issues are ignored.

## Timing
- Reset (async assert, any time, including mid-write): regs all 0, busy all 0, coll_cnt 0. Outputs settle combinationally to rd_data=0, rd_busy=0, dbg_data=0.
- Writes landing on the edge where rst deasserts are ignored if rst is still high at that edge.
- Write latency: 1 edge to storage. Read latency: 0 cycles (combinational).
  - BYPASS=1: effective write-to-read latency is 0.
  - BYPASS=0: new data is visible the cycle after the edge.
- Busy update latency is 1 edge. Issue-to-busy is visible on rd_busy the following cycle.
- coll_cnt updates on the edge that ends the colliding cycle.
- No handshake: all writes are accepted unconditionally. Upstream arbitration decides wr_en.

## Test plan
- Reset/x0: write 0xDEADBEEF to addr 0 via port 0, then read addr 0 → rd_data=0, rd_busy=0. Pulse rst mid-run → every register and coll_cnt read 0.
- Collision priority: same cycle, port 2 writes 0x11 and port 8 writes 0x88 to r5 → after edge regs[5]=0x88 and coll_cnt=1. Same-cycle read of r5 with BYPASS=1 → 0x88.
- Bypass modes: write 0xA5A5A5A5 to r7 with a same-cycle read of r7. BYPASS=1 → 0xA5A5A5A5. BYPASS=0 → old value 0, then 0xA5A5A5A5 the next cycle. dbg_data stays old until the edge.
- Busy lifecycle: issue r3 → rd_busy=1 next cycle. Writeback r3 → busy 0. Same-edge issue r3 and writeback r3 → busy remains 1 and data updated.
- Saturation and parameters: force 65540 collision cycles → coll_cnt=0xFFFF. Rebuild with XLEN=64, DEPTH=64, NUM_WR=4, NUM_RD=3; write 0x1_0000_0000 to r63 and read it on all 3 read ports → all return 0x1_0000_0000.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with priority write-back, optional bypass,
// per-register pending bits and a saturating write-collision counter.

module regfile_mp_rd #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]                addr,
  input  logic [DEPTH-1:0][XLEN-1:0]   regs,
  input  logic [DEPTH-1:0]             busy,
  input  logic [DEPTH-1:0]             hit,
  input  logic [DEPTH-1:0][XLEN-1:0]   win,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  output logic [XLEN-1:0]              data,
  output logic                         busy_o
);
  logic in_range;
  logic fwd;

  // Entry 0 of regs/busy/hit is held at zero, so address 0 needs no special case.
  assign in_range = {1'b0, addr} < (AW+1)'(DEPTH);
  assign fwd      = BYPASS && in_range && hit[addr];

  always_comb begin
    data   = '0;
    busy_o = 1'b0;
    if (in_range) begin
      data   = fwd ? win[addr] : regs[addr];
      busy_o = busy[addr] && !(fwd && !(issue_en && issue_addr == addr));
    end
  end
endmodule

module regfile_mp #(
  parameter int  XLEN   = 32,
  parameter int  DEPTH  = 32,
  localparam int AW     = $clog2(DEPTH),
  parameter int  NUM_WR = 10,
  parameter int  NUM_RD = 2,
  parameter bit  BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_addr,
  input  logic [AW-1:0]            dbg_addr,
  output logic [XLEN-1:0]          dbg_data,
  output logic [15:0]              coll_cnt
);
  logic [DEPTH-1:0][XLEN-1:0] regs;
  logic [DEPTH-1:0]           busy;
  logic [DEPTH-1:0]           hit;
  logic [DEPTH-1:0][XLEN-1:0] win;
  logic [DEPTH-1:0]           iss;
  logic                       coll;

  // Ascending port scan: the last match, i.e. the highest-index port, wins.
  always_comb begin
    hit = '0;
    win = '0;
    iss = '0;
    for (int r = 1; r < DEPTH; r++) begin
      iss[r] = issue_en && issue_addr == AW'(r);
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*AW +: AW] == AW'(r)) begin
          hit[r] = 1'b1;
          win[r] = wr_data[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int k = 0; k < NUM_WR; k++)
      for (int m = k + 1; m < NUM_WR; m++)
        if (wr_en[k] && wr_en[m] && wr_addr[k*AW +: AW] == wr_addr[m*AW +: AW] &&
            wr_addr[k*AW +: AW] != '0)
          coll = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs     <= '0;
      busy     <= '0;
      coll_cnt <= '0;
    end else begin
      regs[0] <= '0;
      busy[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        if (hit[r]) regs[r] <= win[r];
        // A new producer issued on the write-back edge keeps the register pending.
        if (iss[r])      busy[r] <= 1'b1;
        else if (hit[r]) busy[r] <= 1'b0;
      end
      if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end

  assign dbg_data = ({1'b0, dbg_addr} < (AW+1)'(DEPTH)) ? regs[dbg_addr] : '0;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    regfile_mp_rd #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .addr       (rd_addr[j*AW +: AW]),
      .regs       (regs),
      .busy       (busy),
      .hit        (hit),
      .win        (win),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .data       (rd_data[j*XLEN +: XLEN]),
      .busy_o     (rd_busy[j])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default bypassing file, a non-bypassing twin
// on the same stimulus, and a wide 64x64 / 4W / 3R build.

module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default-size stimulus shared by u_dut (BYPASS=1) and u_nb (BYPASS=0)
  logic [9:0]    rd_addr;
  logic [9:0]    wr_en;
  logic [49:0]   wr_addr;
  logic [319:0]  wr_data;
  logic          issue_en;
  logic [4:0]    issue_addr, dbg_addr;
  logic [63:0]   rd_data_a, rd_data_b;
  logic [1:0]    rd_busy_a, rd_busy_b;
  logic [31:0]   dbg_a, dbg_b;
  logic [15:0]   coll_a, coll_b;

  // wide build
  logic [17:0]   w_rd_addr;
  logic [191:0]  w_rd_data;
  logic [2:0]    w_rd_busy;
  logic [3:0]    w_wr_en;
  logic [23:0]   w_wr_addr;
  logic [255:0]  w_wr_data;
  logic [63:0]   w_dbg;
  logic [15:0]   w_coll;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_a), .coll_cnt(coll_a));

  regfile_mp #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_b), .coll_cnt(coll_b));

  regfile_mp #(.XLEN(64), .DEPTH(64), .NUM_WR(4), .NUM_RD(3)) u_big (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .issue_en(1'b0),
    .issue_addr(6'd0), .dbg_addr(6'd0), .dbg_data(w_dbg), .coll_cnt(w_coll));

  typedef enum int {RD0, RD1, BSY0, BSY1, DBG, COLL, NB_RD1, NB_BSY0, NB_DBG, W0, W1, W2} sel_t;
  typedef struct { string tag; sel_t sel; logic [63:0] exp; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] obs(sel_t s);
    case (s)
      RD0:     return {32'd0, rd_data_a[31:0]};
      RD1:     return {32'd0, rd_data_a[63:32]};
      BSY0:    return {63'd0, rd_busy_a[0]};
      BSY1:    return {63'd0, rd_busy_a[1]};
      DBG:     return {32'd0, dbg_a};
      COLL:    return {48'd0, coll_a};
      NB_RD1:  return {32'd0, rd_data_b[63:32]};
      NB_BSY0: return {63'd0, rd_busy_b[0]};
      NB_DBG:  return {32'd0, dbg_b};
      W0:      return w_rd_data[63:0];
      W1:      return w_rd_data[127:64];
      W2:      return w_rd_data[191:128];
      default: return 'x;
    endcase
  endfunction

  task automatic exp_push(input string tag, input sel_t s, input logic [63:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.exp = e;
    sb.push_back(x);
  endtask

  // settle combinational outputs, then compare everything queued
  task automatic drain();
    exp_t x;
    logic [63:0] o;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sel);
      checks++;
      assert (o === x.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_en = '0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_addr = '0;
    w_wr_en = '0; w_wr_addr = '0; w_wr_data = '0;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
    wr_en[k] = 1'b1; wr_addr[k*5 +: 5] = a; wr_data[k*32 +: 32] = d;
  endtask

  task automatic rd(input int j, input logic [4:0] a);
    rd_addr[j*5 +: 5] = a;
  endtask

  initial begin
    clr(); rd_addr = '0; dbg_addr = '0; w_rd_addr = '0;
    step(); step();
    // reset state
    rd(0, 5'd3); rd(1, 5'd9); dbg_addr = 5'd3;
    exp_push("reset_rd0", RD0, 0); exp_push("reset_busy0", BSY0, 0);
    exp_push("reset_dbg", DBG, 0); exp_push("reset_coll", COLL, 0);
    drain();
    rst = 1'b0;

    // write to x0 is ignored
    wr(0, 5'd0, 32'hDEADBEEF); rd(0, 5'd0); dbg_addr = 5'd0;
    exp_push("x0_bypass_rd", RD0, 0); drain();
    step(); clr();
    exp_push("x0_rd", RD0, 0); exp_push("x0_busy", BSY0, 0); exp_push("x0_dbg", DBG, 0);
    drain();

    // collision priority: port 8 beats port 2
    wr(2, 5'd5, 32'h11); wr(8, 5'd5, 32'h88); rd(0, 5'd5); dbg_addr = 5'd5;
    exp_push("coll_bypass", RD0, 32'h88); exp_push("coll_dbg_old", DBG, 0);
    drain();
    step(); clr();
    exp_push("coll_stored", RD0, 32'h88); exp_push("coll_dbg", DBG, 32'h88);
    exp_push("coll_cnt1", COLL, 1);
    drain();

    // bypass vs. stored-only read of r7
    wr(0, 5'd7, 32'hA5A5A5A5); rd(1, 5'd7); dbg_addr = 5'd7;
    exp_push("byp_on", RD1, 32'hA5A5A5A5); exp_push("byp_off_old", NB_RD1, 0);
    exp_push("byp_dbg_old", DBG, 0); exp_push("byp_nb_dbg_old", NB_DBG, 0);
    drain();
    step(); clr();
    exp_push("byp_off_new", NB_RD1, 32'hA5A5A5A5); exp_push("byp_dbg_new", DBG, 32'hA5A5A5A5);
    exp_push("byp_coll_same", COLL, 1);
    drain();

    // busy lifecycle on r3
    issue_en = 1'b1; issue_addr = 5'd3; rd(0, 5'd3);
    exp_push("busy_pre_issue", BSY0, 0); drain();
    step(); clr();
    exp_push("busy_after_issue", BSY0, 1); drain();
    wr(4, 5'd3, 32'h33);
    exp_push("busy_fwd_clear", BSY0, 0); exp_push("busy_nb_stored", NB_BSY0, 1);
    drain();
    step(); clr();
    exp_push("busy_after_wb", BSY0, 0); exp_push("wb_data", RD0, 32'h33); drain();
    issue_en = 1'b1; issue_addr = 5'd3; wr(6, 5'd3, 32'h66);
    exp_push("busy_same_edge_pre", BSY0, 0); drain();
    step(); clr();
    exp_push("busy_same_edge", BSY0, 1); exp_push("same_edge_data", RD0, 32'h66); drain();

    // two colliding pairs in one cycle count once
    wr(0, 5'd9, 32'h1); wr(1, 5'd9, 32'h2); wr(2, 5'd10, 32'h3); wr(3, 5'd10, 32'h4);
    step(); clr(); rd(0, 5'd9); rd(1, 5'd10);
    exp_push("pairs_cnt", COLL, 2); exp_push("pairs_r9", RD0, 32'h2);
    exp_push("pairs_r10", RD1, 32'h4);
    drain();

    // asynchronous reset mid-run, write held across the still-reset edge
    #2 rst = 1'b1; dbg_addr = 5'd5;
    exp_push("arst_r9", RD0, 0); exp_push("arst_r10", RD1, 0);
    exp_push("arst_dbg", DBG, 0); exp_push("arst_coll", COLL, 0);
    drain();
    wr(0, 5'd4, 32'h44);
    step(); rst = 1'b0; clr(); rd(0, 5'd4); rd(1, 5'd3);
    exp_push("rst_edge_write", RD0, 0); exp_push("rst_busy", BSY1, 0); drain();

    // saturation
    wr(0, 5'd1, 32'h1); wr(1, 5'd1, 32'h2);
    repeat (100) step();
    exp_push("coll_count100", COLL, 100); drain();
    repeat (65440) step();
    clr();
    exp_push("coll_sat", COLL, 16'hFFFF); drain();
    step();
    exp_push("coll_sat_hold", COLL, 16'hFFFF); drain();

    // wide build: r63 read on all three ports
    w_wr_en[3] = 1'b1; w_wr_addr[18 +: 6] = 6'd63; w_wr_data[192 +: 64] = 64'h1_0000_0000;
    w_rd_addr = {6'd63, 6'd63, 6'd63};
    exp_push("wide_bypass", W0, 64'h1_0000_0000); drain();
    step(); clr();
    exp_push("wide_rd0", W0, 64'h1_0000_0000); exp_push("wide_rd1", W1, 64'h1_0000_0000);
    exp_push("wide_rd2", W2, 64'h1_0000_0000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
